// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pops words from a FIFO whose RAM output arrives one cycle after the pop
// request and presents them downstream on a valid/ready stream, with a
// 2-entry skid buffer so a full word per cycle is sustained.
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   empty        FIFO empty flag, same cycle as read_request
//   read_request FIFO pop request (combinational)
//   read_data    FIFO RAM output, valid the cycle after an accepted request
//   out_valid    downstream valid (registered)
//   out_ready    downstream ready
//   out_data     downstream data, head buffer entry (registered)
//   delivered    wrapping count of words handed downstream
//   busy         words buffered or a read in flight
module fifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             empty,
    output logic             read_request,
    input  logic [WIDTH-1:0] read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] delivered,
    output logic             busy
);

    // State value equals buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    buf_state_t       state;
    buf_state_t       state_next;
    logic             pend;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       demand;

    always_comb begin
        occ          = state;
        pop          = (state != EMPTY) & out_ready;
        // Slots that will be committed after this edge; a new read is only
        // allowed while at most one slot is spoken for.
        demand       = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
        read_request = ~empty & reset & (demand <= 3'd1);
        // Next occupancy is occ - pop + pend, which is demand's low bits.
        case (demand[1:0])
            2'd0:    state_next = EMPTY;
            2'd1:    state_next = ONE;
            default: state_next = TWO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            pend  <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pend  <= read_request;
            if (pop && state == TWO) begin
                head <= tail;
            end
            // Arriving word lands in head only if nothing will be left ahead
            // of it; with a pop out of TWO this writes the new tail.
            if (pend) begin
                if (occ == {1'b0, pop}) begin
                    head <= read_data;
                end else begin
                    tail <= read_data;
                end
            end
            if (pop) begin
                count <= count + 1'b1;
            end
        end
    end

    assign out_valid = (state != EMPTY);
    assign out_data  = head;
    assign delivered = count;
    assign busy      = (state != EMPTY) | pend;

    occ_bound: assert property (@(posedge clk) disable iff (!reset)
        !(pend && state == TWO && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             empty = 1'b1;
    logic             read_request;
    logic [WIDTH-1:0] read_data = '0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] delivered;
    logic             busy;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .empty(empty), .read_request(read_request),
        .read_data(read_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .delivered(delivered), .busy(busy)
    );

    int total = 0;
    int bad = 0;

    logic [WIDTH-1:0] fifo_q[$];   // words still inside the external FIFO
    logic [WIDTH-1:0] exp_q[$];    // words popped from FIFO, not yet delivered
    bit               have_word = 0;
    bit               inflight = 0;
    logic [WIDTH-1:0] next_word;
    bit               hold_empty = 0;
    int               dcount = 0;
    int               npops = 0;
    int               nreqs = 0;
    bit               prev_stall = 0;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] last_popped;
    int               buffered;
    bit               pop_now;
    bit               exp_rr;
    logic [WIDTH-1:0] w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // FIFO RAM model: word appears the cycle after the accepted request.
    always @(posedge clk) begin
        #2;
        inflight  = have_word;
        if (have_word) read_data = next_word;
        have_word = 0;
        empty     = hold_empty || (fifo_q.size() == 0);
    end

    // Reference model + scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_rr", read_request, 0);
            check("rst_valid", out_valid, 0);
            check("rst_data", out_data, 0);
            check("rst_delivered", delivered, 0);
            check("rst_busy", busy, 0);
            exp_q.delete();
            have_word  = 0;
            inflight   = 0;
            dcount     = 0;
            prev_stall = 0;
        end else begin
            buffered = exp_q.size() - (inflight ? 1 : 0);
            check("valid", out_valid, buffered > 0);
            check("busy", busy, exp_q.size() != 0);
            check("delivered", delivered, dcount % (1 << CNT_W));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            pop_now = (buffered > 0) && out_ready;
            exp_rr  = !empty && ((exp_q.size() - (pop_now ? 1 : 0)) <= 1);
            check("read_request", read_request, exp_rr);
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    check("pop_underflow", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("data_order", out_data, w);
                    last_popped = w;
                end
                dcount++;
                npops++;
            end
            prev_stall = (buffered > 0) && !out_ready;
            prev_data  = out_data;
            if (read_request) begin
                if (fifo_q.size() == 0) begin
                    check("read_on_empty_fifo", 1, 0);
                end else begin
                    w = fifo_q.pop_front();
                    exp_q.push_back(w);
                    next_word = w;
                    have_word = 1;
                    nreqs++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int n0;
    int p0;
    int start;
    bit hit;
    logic [WIDTH-1:0] first_exp;

    initial begin
        reset     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);

        // Three words, downstream always ready.
        fifo_q = '{8'h11, 8'h22, 8'h33};
        out_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); #1 check("t1_c0_rr", read_request, 1); check("t1_c0_valid", out_valid, 0);
        @(negedge clk); #1 check("t1_c1_rr", read_request, 1); check("t1_c1_valid", out_valid, 0);
        @(negedge clk); #1 check("t1_c2_data", out_data, 8'h11); check("t1_c2_rr", read_request, 1);
        @(negedge clk); #1 check("t1_c3_data", out_data, 8'h22); check("t1_c3_rr", read_request, 0);
        @(negedge clk); #1 check("t1_c4_data", out_data, 8'h33); check("t1_c4_valid", out_valid, 1);
        @(negedge clk); #1 check("t1_c5_busy", busy, 0); check("t1_c5_delivered", delivered, 3);

        // Five words, stalled downstream for ten cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(WIDTH'(8'hA0 + i));
        n0 = nreqs;
        repeat (10) @(posedge clk);
        #1 check("t2_reads", nreqs - n0, 2);
        check("t2_valid", out_valid, 1);
        check("t2_head", out_data, 8'hA0);
        out_ready = 1'b1;
        p0 = npops;
        repeat (5) @(negedge clk);
        #1 check("t2_burst", npops - p0, 5);
        repeat (3) @(posedge clk);

        // Random empty / ready.
        start = npops;
        for (int c = 0; c < 20000 && (npops - start) < 1000; c++) begin
            @(posedge clk); #1;
            out_ready  = ($urandom_range(0, 9) < 7);
            hold_empty = ($urandom_range(0, 9) < 3);
            while (fifo_q.size() < 3) fifo_q.push_back(WIDTH'($urandom));
        end
        check("t3_words", (npops - start) >= 1000, 1);
        // Empty held high: buffered words drain, no reads issued.
        @(posedge clk); #1 hold_empty = 1'b1; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("t3_drained", busy, 0);
        fifo_q.delete();
        hold_empty = 1'b0;

        // Reset mid-transfer with a buffered word and a read in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(WIDTH'(8'hB0 + i));
        @(posedge clk);
        @(posedge clk); #3;
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("t5_async_rr", read_request, 0);
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 0);
        check("t5_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 first_exp = fifo_q[0];
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk); #1 check("t5_first_rr", read_request, 1);
        p0 = npops;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk); #1;
            if (npops != p0) hit = 1;
        end
        check("t5_first_word", hit ? last_popped : 'x, first_exp);
        repeat (6) @(posedge clk);

        // Delivered counter wrap.
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        fifo_q.delete();
        for (int i = 0; i < 17; i++) fifo_q.push_back(WIDTH'(8'h40 + i));
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk); #1;
            if (dcount >= 16) hit = 1;
        end
        check("t4_reach16", hit, 1);
        @(posedge clk); #1 check("t4_wrap0", delivered, 0);
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk); #1;
            if (dcount >= 17) hit = 1;
        end
        @(posedge clk); #1 check("t4_end1", delivered, 1);

        // Ready toggling with a steady supply.
        for (int i = 0; i < 12; i++) fifo_q.push_back(WIDTH'($urandom));
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1 out_ready = (c % 2 == 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("final_fifo_empty", fifo_q.size(), 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
